// File: rtl/npu_csr_energy_responder.sv
// CSR target for the NPU top level: 64-bit energy accumulator with coherent
// LO/HI readout, sticky status register and DVFS utilization thresholds.
//
// state   | meaning
// IDLE    | waiting for csr_valid; request fields captured on acceptance
// RESP    | access performed; ready/rdata registered for the next cycle
// RELEASE | completion issued; waiting for the initiator to drop csr_valid
module npu_csr_energy_responder #(
  parameter int          ENERGY_INC_W  = 16,
  parameter logic [6:0]  UTIL_HIGH_RST = 7'd85,
  parameter logic [6:0]  UTIL_LOW_RST  = 7'd40,
  parameter logic [31:0] BLOCK_ID      = 32'h4E45_0E01
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    csr_valid,
  input  logic                    csr_write,
  input  logic [7:0]              csr_addr,
  input  logic [31:0]             csr_wdata,
  output logic [31:0]             csr_rdata,
  output logic                    csr_ready,
  input  logic [ENERGY_INC_W-1:0] energy_inc,
  output logic [6:0]              util_high_pct,
  output logic [6:0]              util_low_pct,
  output logic                    thresh_update
);

  typedef enum logic [1:0] {IDLE, RESP, RELEASE} state_t;

  localparam logic [7:0] A_ID   = 8'h00;
  localparam logic [7:0] A_LO   = 8'h60;
  localparam logic [7:0] A_HI   = 8'h64;
  localparam logic [7:0] A_CTRL = 8'h68;
  localparam logic [7:0] A_STAT = 8'h6C;
  localparam logic [7:0] A_UH   = 8'hA0;
  localparam logic [7:0] A_UL   = 8'hA4;

  state_t      state, state_nxt;
  logic [7:2]  addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [63:0] energy;
  logic [31:0] hi_shadow;
  logic [3:0]  status;
  logic [64:0] energy_sum;
  logic [7:0]  word;
  logic [31:0] rd_val;
  logic [6:0]  thr_val;
  logic [3:0]  status_set;
  logic        access, rd_en, wr_en, rd_mapped, wr_ok;
  logic        clr_energy, thr_clamp, thr_hit, sat;

  assign word       = {addr_q, 2'b00};
  assign energy_sum = {1'b0, energy} + {{(65-ENERGY_INC_W){1'b0}}, energy_inc};
  assign rd_en      = access & ~write_q;
  assign wr_en      = access & write_q;
  assign clr_energy = wr_en & (word == A_CTRL) & wdata_q[0];
  assign thr_hit    = (word == A_UH) | (word == A_UL);
  assign thr_clamp  = wdata_q > 32'd100;
  assign thr_val    = thr_clamp ? 7'd100 : wdata_q[6:0];
  // a clear in the same cycle discards the increment, so it cannot saturate
  assign sat        = energy_sum[64] & ~clr_energy;
  assign status_set = {rd_en & ~rd_mapped, wr_en & thr_hit & thr_clamp,
                       wr_en & ~wr_ok, sat};

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE:    if (csr_valid) state_nxt = RESP;
      RESP: begin
        access    = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: if (!csr_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_val    = '0;
    rd_mapped = 1'b1;
    wr_ok     = 1'b0;
    case (word)
      A_ID:   rd_val = BLOCK_ID;
      A_LO:   rd_val = energy[31:0];
      A_HI:   rd_val = hi_shadow;
      A_CTRL: wr_ok  = 1'b1;
      A_STAT: begin
        rd_val = {28'd0, status};
        wr_ok  = 1'b1;
      end
      A_UH: begin
        rd_val = {25'd0, util_high_pct};
        wr_ok  = 1'b1;
      end
      A_UL: begin
        rd_val = {25'd0, util_low_pct};
        wr_ok  = 1'b1;
      end
      default: rd_mapped = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      csr_ready     <= 1'b0;
      csr_rdata     <= '0;
      thresh_update <= 1'b0;
      energy        <= '0;
      hi_shadow     <= '0;
      status        <= '0;
      util_high_pct <= UTIL_HIGH_RST;
      util_low_pct  <= UTIL_LOW_RST;
    end else begin
      state <= state_nxt;
      if (state == IDLE && csr_valid) begin
        addr_q  <= csr_addr[7:2];
        write_q <= csr_write;
        wdata_q <= csr_wdata;
      end
      csr_ready     <= access;
      csr_rdata     <= rd_en ? rd_val : 32'd0;
      thresh_update <= wr_en & thr_hit;

      if (clr_energy)          energy <= '0;
      else if (energy_sum[64]) energy <= '1;
      else                     energy <= energy_sum[63:0];

      // LO read freezes the upper word so a following HI read is coherent
      if (clr_energy)                  hi_shadow <= '0;
      else if (rd_en && word == A_LO)  hi_shadow <= energy[63:32];

      if (wr_en && word == A_STAT) status <= (status & ~wdata_q[3:0]) | status_set;
      else                         status <= status | status_set;

      if (wr_en && word == A_UH) util_high_pct <= thr_val;
      if (wr_en && word == A_UL) util_low_pct  <= thr_val;
    end
  end

endmodule

// File: tb/tb_npu_csr_energy_responder.sv
// Bench for npu_csr_energy_responder: two instances (16-bit and 64-bit increment)
// share one CSR initiator; a cycle-level reference model predicts every response.
module tb_npu_csr_energy_responder;
  localparam logic [31:0] ID = 32'h4E45_0E01;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_valid, csr_write;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, tu_a, tu_b;
  logic [15:0] inc_a;
  logic [63:0] inc_b;
  logic [6:0]  uh_a, ul_a, uh_b, ul_b;

  always #5 clk = ~clk;

  npu_csr_energy_responder dut_a (
    .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_write(csr_write),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(rdata_a), .csr_ready(ready_a),
    .energy_inc(inc_a), .util_high_pct(uh_a), .util_low_pct(ul_a), .thresh_update(tu_a));

  npu_csr_energy_responder #(.ENERGY_INC_W(64)) dut_b (
    .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_write(csr_write),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(rdata_b), .csr_ready(ready_b),
    .energy_inc(inc_b), .util_high_pct(uh_b), .util_low_pct(ul_b), .thresh_update(tu_b));

  int n_chk = 0;
  int n_fail = 0;

  // reference model state, index 0 = dut_a, 1 = dut_b
  logic [63:0] m_e [2];
  logic [31:0] m_sh [2];
  logic [3:0]  m_st [2];
  logic [6:0]  m_uh, m_ul;
  logic [31:0] exp_rd [2];
  bit          exp_tu;
  bit          cur_wr;
  logic [7:0]  cur_addr;
  logic [31:0] cur_wd;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } vec_t;
  vec_t vecs[$];

  logic [7:0] amap [10] = '{8'h00, 8'h60, 8'h64, 8'h68, 8'h6C, 8'hA0, 8'hA4, 8'h10, 8'hFC, 8'h61};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_e[i] = '0; m_sh[i] = '0; m_st[i] = '0; exp_rd[i] = '0;
    end
    m_uh = 7'd85; m_ul = 7'd40;
  endtask

  // one clock edge; commit=1 marks the edge at which the pending request is performed
  task automatic tick(input bit commit);
    logic [63:0] inc;
    logic [7:0]  w;
    bit          clr;
    w      = {cur_addr[7:2], 2'b00};
    clr    = commit && cur_wr && (w == 8'h68) && cur_wd[0];
    exp_tu = commit && cur_wr && (w == 8'hA0 || w == 8'hA4);
    if (reset) m_reset();
    else for (int i = 0; i < 2; i++) begin
      inc = (i == 0) ? 64'(inc_a) : inc_b;
      if (commit) begin
        exp_rd[i] = '0;
        if (!cur_wr) begin
          case (w)
            8'h00: exp_rd[i] = ID;
            8'h60: begin exp_rd[i] = m_e[i][31:0]; m_sh[i] = m_e[i][63:32]; end
            8'h64: exp_rd[i] = m_sh[i];
            8'h68: exp_rd[i] = '0;
            8'h6C: exp_rd[i] = {28'd0, m_st[i]};
            8'hA0: exp_rd[i] = {25'd0, m_uh};
            8'hA4: exp_rd[i] = {25'd0, m_ul};
            default: m_st[i][3] = 1'b1;
          endcase
        end else begin
          case (w)
            8'h68: ;
            8'h6C: m_st[i] = m_st[i] & ~cur_wd[3:0];
            8'hA0, 8'hA4: begin
              if (cur_wd > 100) m_st[i][2] = 1'b1;
              if (w == 8'hA0) m_uh = (cur_wd > 100) ? 7'd100 : cur_wd[6:0];
              else            m_ul = (cur_wd > 100) ? 7'd100 : cur_wd[6:0];
            end
            default: m_st[i][1] = 1'b1;
          endcase
        end
      end
      if (clr) begin
        m_e[i] = '0; m_sh[i] = '0;
      end else if (m_e[i] > ~64'd0 - inc) begin
        m_e[i] = ~64'd0; m_st[i][0] = 1'b1;
      end else m_e[i] = m_e[i] + inc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr(input bit wr, input logic [7:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd_a, output logic [31:0] rd_b);
    cur_wr = wr; cur_addr = a; cur_wd = wd;
    csr_valid = 1'b1; csr_write = wr; csr_addr = a; csr_wdata = wd;
    tick(1'b0);
    chk("early_ready", {ready_a, ready_b, tu_a, tu_b}, 0);
    tick(1'b1);
    chk("ready", {ready_a, ready_b}, 2'b11);
    chk("rdata_a", rdata_a, exp_rd[0]);
    chk("rdata_b", rdata_b, exp_rd[1]);
    chk("thresh_update", {tu_a, tu_b}, {exp_tu, exp_tu});
    chk("util_pct", {uh_a, ul_a, uh_b, ul_b}, {m_uh, m_ul, m_uh, m_ul});
    rd_a = rdata_a; rd_b = rdata_b;
    for (int k = 0; k < hold; k++) begin
      tick(1'b0);
      chk("held_no_ready", {ready_a, ready_b, tu_a, tu_b}, 0);
    end
    csr_valid = 1'b0;
    tick(1'b0);
    chk("ready_drop", {ready_a, ready_b, tu_a, tu_b}, 0);
  endtask

  task automatic add(input bit wr, input logic [7:0] a, input logic [31:0] wd, input logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.wd = wd; v.rd = rd;
    vecs.push_back(v);
  endtask

  logic [31:0] ra, rb, lo1, hi1, lo2, hi2;
  logic [63:0] e1, e2;

  initial begin
    reset = 1'b1; csr_valid = 1'b0; csr_write = 1'b0; csr_addr = '0; csr_wdata = '0;
    inc_a = '0; inc_b = '0; cur_wr = 1'b0; cur_addr = '0; cur_wd = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_outputs", {ready_a, ready_b, tu_a, tu_b, rdata_a, rdata_b}, 0);
    chk("reset_thresh", {uh_a, ul_a, uh_b, ul_b}, {7'd85, 7'd40, 7'd85, 7'd40});
    reset = 1'b0;

    csr(1'b0, 8'h00, 0, 3, ra, rb);
    chk("id_read", ra, ID);

    add(1, 8'h6C, 32'hF, 0);   add(1, 8'hA0, 80, 0);      add(1, 8'hA4, 50, 0);
    add(0, 8'hA0, 0, 80);      add(0, 8'hA4, 0, 50);      add(0, 8'h6C, 0, 0);
    add(1, 8'hA0, 150, 0);     add(0, 8'hA0, 0, 100);     add(0, 8'h6C, 0, 4);
    add(1, 8'h6C, 4, 0);       add(0, 8'h6C, 0, 0);       add(1, 8'h60, 5, 0);
    add(0, 8'h6C, 0, 2);       add(0, 8'h10, 0, 0);       add(0, 8'h6C, 0, 32'hA);
    add(1, 8'h6C, 32'hF, 0);   add(0, 8'h68, 0, 0);       add(1, 8'hA4, 101, 0);
    add(0, 8'hA4, 0, 100);     add(0, 8'h6C, 0, 4);       add(1, 8'h6C, 32'hF, 0);
    add(1, 8'hA4, 100, 0);     add(0, 8'h6C, 0, 0);       add(1, 8'hA4, 40, 0);
    add(0, 8'hA3, 0, 100);     add(0, 8'h00, 0, ID);
    foreach (vecs[i]) begin
      csr(vecs[i].wr, vecs[i].addr, vecs[i].wd, i % 2, ra, rb);
      chk($sformatf("vec%0d", i), ra, vecs[i].rd);
    end

    inc_a = 16'd5;
    repeat (2000) tick(1'b0);
    csr(1'b0, 8'h60, 0, 0, lo1, rb);
    csr(1'b0, 8'h64, 0, 0, hi1, rb);
    e1 = {hi1, lo1};
    chk("energy_range", (e1 >= 64'd10000 && e1 <= 64'd10015), 1);
    csr(1'b0, 8'h60, 0, 0, lo2, rb);
    csr(1'b0, 8'h64, 0, 0, hi2, rb);
    e2 = {hi2, lo2};
    chk("energy_monotonic", (e2 >= e1), 1);

    inc_a = 16'd7;
    csr(1'b1, 8'h68, 1, 0, ra, rb);
    csr(1'b0, 8'h60, 0, 0, ra, rb);
    chk("clear_wins_lo", ra, 14);
    csr(1'b0, 8'h64, 0, 0, ra, rb);
    chk("clear_wins_hi", ra, 0);

    inc_b = 64'hFFFF_FFD0;
    tick(1'b0);
    inc_b = 64'd32;
    csr(1'b0, 8'h60, 0, 0, ra, rb);
    chk("rollover_lo", rb, 32'hFFFF_FFF0);
    csr(1'b0, 8'h64, 0, 0, ra, rb);
    chk("rollover_hi_snapshot", rb, 0);
    csr(1'b0, 8'h60, 0, 0, ra, rb);
    csr(1'b0, 8'h64, 0, 0, ra, rb);
    chk("rollover_hi_after", rb, 1);

    inc_b = ~64'd0;
    tick(1'b0);
    inc_b = '0;
    csr(1'b0, 8'h6C, 0, 0, ra, rb);
    chk("sat_status_b", rb[0], 1);
    chk("sat_status_a", ra[0], 0);
    csr(1'b0, 8'h60, 0, 0, ra, rb);
    chk("sat_lo", rb, 32'hFFFF_FFFF);
    csr(1'b1, 8'h6C, 1, 0, ra, rb);
    csr(1'b0, 8'h6C, 0, 0, ra, rb);
    chk("sat_w1c", rb[0], 0);

    for (int n = 0; n < 60; n++) begin
      inc_a = 16'($urandom_range(0, 65535));
      inc_b = 64'($urandom_range(0, 1000));
      csr(1'($urandom_range(0, 1)), amap[$urandom_range(0, 9)],
          ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 130)) : $urandom,
          $urandom_range(0, 2), ra, rb);
      repeat ($urandom_range(0, 2)) tick(1'b0);
    end

    cur_wr = 1'b1; cur_addr = 8'hA0; cur_wd = 32'd20;
    csr_valid = 1'b1; csr_write = 1'b1; csr_addr = 8'hA0; csr_wdata = 32'd20;
    tick(1'b0);
    reset = 1'b1;
    m_reset();
    #1;
    chk("abort_thresh", {uh_a, ul_a, uh_b, ul_b}, {7'd85, 7'd40, 7'd85, 7'd40});
    chk("abort_outputs", {ready_a, ready_b, tu_a, tu_b, rdata_a, rdata_b}, 0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tick(1'b0);
      chk("abort_no_ready", {ready_a, ready_b, uh_a, ul_a}, {2'b00, 7'd85, 7'd40});
    end
    reset = 1'b0;
    csr(1'b1, 8'hA0, 32'd20, 0, ra, rb);
    chk("reaccept_after_reset", uh_a, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
